// File: rtl/fetch_seq32.sv
// Fetch sequencer / PC controller: fetches instruction words over a req/ack
// handshake, feeds the decoder slot, and redirects the PC on taken branches.
module fetch_seq32 #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN  = 32'hE1A0_0000,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  output logic [31:0] dec_iin,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        br_link,
  output logic        lr_we,
  output logic [31:0] lr_data
);

  typedef enum logic [2:0] {S_BOOT, S_RUN, S_HOLD, S_DRAIN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] dec_iin_q, dec_iin_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        lr_we_q, lr_we_d;
  logic [31:0] lr_data_q, lr_data_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        br_accept;
  logic        fetching;
  logic [31:0] br_target;

  assign fetching  = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign br_accept = br_taken && (flush_cnt_q == '0) &&
                     ((state_q == S_RUN) || (state_q == S_HOLD));
  assign br_target = ex_pc_q + 32'd8 + br_offset;

  // A draining request keeps its pre-branch address while pc already holds the target.
  assign imem_req  = fetching || (state_q == S_DRAIN);
  assign imem_addr = (state_q == S_DRAIN) ? fa_q : pc_q;
  assign dec_iin   = dec_iin_q;
  assign dec_valid = dec_valid_q;
  assign dec_pc    = dec_pc_q;
  assign lr_we     = lr_we_q;
  assign lr_data   = lr_data_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fa_d         = fa_q;
    dec_iin_d    = dec_iin_q;
    dec_valid_d  = dec_valid_q;
    dec_pc_d     = dec_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    lr_we_d      = 1'b0;
    lr_data_d    = lr_data_q;
    ex_pc_d      = stall_in ? ex_pc_q : dec_pc_q;
    flush_cnt_d  = (flush_cnt_q != '0) ? flush_cnt_q - 8'd1 : '0;

    if (br_accept) begin
      pc_d         = {br_target[31:2], 2'b00};
      fa_d         = pc_q;
      dec_iin_d    = NOP_INSN;
      dec_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      flush_cnt_d  = 8'(FLUSH_CYC);
      if (br_link) begin
        lr_we_d   = 1'b1;
        lr_data_d = ex_pc_q + 32'd4;
      end
      state_d = (fetching && !imem_ack) ? S_DRAIN : S_FLUSH;
    end else begin
      case (state_q)
        S_BOOT: begin
          dec_iin_d   = NOP_INSN;
          dec_valid_d = 1'b0;
          state_d     = S_RUN;
        end
        S_RUN, S_FLUSH: begin
          if (state_q == S_FLUSH && flush_cnt_q <= 8'd1) state_d = S_RUN;
          if (imem_ack && stall_in) begin
            skid_valid_d = 1'b1;
            skid_data_d  = imem_rdata;
            skid_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_HOLD;
          end else if (!stall_in) begin
            if (imem_ack) begin
              dec_iin_d   = imem_rdata;
              dec_valid_d = 1'b1;
              dec_pc_d    = pc_q;
              pc_d        = pc_q + 32'd4;
            end else begin
              dec_iin_d   = NOP_INSN;
              dec_valid_d = 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            dec_iin_d    = skid_valid_q ? skid_data_q : NOP_INSN;
            dec_valid_d  = skid_valid_q;
            if (skid_valid_q) dec_pc_d = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = S_RUN;
          end
        end
        S_DRAIN: begin
          dec_iin_d   = NOP_INSN;
          dec_valid_d = 1'b0;
          if (imem_ack) state_d = S_FLUSH;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VEC;
      fa_q         <= '0;
      ex_pc_q      <= '0;
      dec_iin_q    <= NOP_INSN;
      dec_valid_q  <= 1'b0;
      dec_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      lr_we_q      <= 1'b0;
      lr_data_q    <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fa_q         <= fa_d;
      ex_pc_q      <= ex_pc_d;
      dec_iin_q    <= dec_iin_d;
      dec_valid_q  <= dec_valid_d;
      dec_pc_q     <= dec_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      lr_we_q      <= lr_we_d;
      lr_data_q    <= lr_data_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_seq32.sv
// Bench for fetch_seq32: directed handshake/branch/stall/reset steps, then a
// randomized ack/stall run checked against an in-order fetch/decode scoreboard.
module tb_fetch_seq32;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_in = 1'b0;
  logic [31:0] dec_iin;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        br_link = 1'b0;
  logic        lr_we;
  logic [31:0] lr_data;

  int vectors = 0;
  int miscompares = 0;

  fetch_seq32 #(.RESET_VEC(32'h0000_0000), .NOP_INSN(NOP), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_in(stall_in),
    .dec_iin(dec_iin), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .br_taken(br_taken), .br_offset(br_offset), .br_link(br_link),
    .lr_we(lr_we), .lr_data(lr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ack, input logic stall, input logic br,
                     input logic link, input logic [31:0] off);
    imem_ack   = ack;
    imem_rdata = memf(imem_addr);
    stall_in   = stall;
    br_taken   = br;
    br_link    = link;
    br_offset  = off;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_iin"}, dec_iin, NOP);
    chk1({tag, "_valid"}, dec_valid, 1'b0);
    chk({tag, "_pc"}, dec_pc, 32'h0);
    chk1({tag, "_lrwe"}, lr_we, 1'b0);
    chk({tag, "_lrdata"}, lr_data, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc);
    chk1({tag, "_valid"}, dec_valid, 1'b1);
    chk({tag, "_pc"}, dec_pc, pc);
    chk({tag, "_iin"}, dec_iin, memf(pc));
  endtask

  initial begin
    logic [31:0] exp_fetch, prev_addr, prev_pc, prev_iin, exp_pc;
    logic        prev_stall, prev_pend, prev_valid, a, s;
    logic [31:0] q[$];
    int          guard;

    // Reset values and sequential fetch with ack every cycle
    #1;
    do_reset();
    chk_reset_vals("reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("boot_to_run_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    chk1("stale_boot_ack", dec_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("seq_addr", imem_addr, 32'(4 * i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_dec("seq_dec", 32'(4 * i));
    end

    // ack delayed three cycles at address 8
    for (int k = 0; k < 3; k++) begin
      chk1("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, 32'h8);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk1("wait_valid", dec_valid, 1'b0);
      chk("wait_iin", dec_iin, NOP);
    end
    chk("wait_addr_end", imem_addr, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("after_wait", 32'h8);
    chk("addr_c", imem_addr, 32'hC);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("dec_c", 32'hC);

    // stall with fetch outstanding at 0x10: word goes to the skid buffer
    chk("stall_addr", imem_addr, 32'h10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("stall_req_held", imem_req, 1'b1);
    chk("stall_addr_held", imem_addr, 32'h10);
    chk_dec("stall_dec_hold", 32'hC);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("hold_no_req", imem_req, 1'b0);
    chk_dec("hold_dec", 32'hC);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk1("hold_no_req2", imem_req, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("skid_issue", 32'h10);
    chk1("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 32'h14);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("resume_dec", 32'h14);

    // Advance until the decoder shows 0x24, so the executing pc is 0x20
    guard = 0;
    while (dec_pc !== 32'h24 && guard < 10) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      guard++;
    end
    chk("reach_24", dec_pc, 32'h24);
    chk("addr_28", imem_addr, 32'h28);

    // Linked branch with simultaneous ack, then br_taken held (sticky)
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
    chk("br_target", imem_addr, 32'h68);
    chk1("br_req", imem_req, 1'b1);
    chk1("br_lrwe", lr_we, 1'b1);
    chk("br_lrdata", lr_data, 32'h24);
    chk1("br_squash_valid", dec_valid, 1'b0);
    chk("br_squash_iin", dec_iin, NOP);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      chk1("sticky_lrwe", lr_we, 1'b0);
      chk("sticky_addr", imem_addr, 32'h68);
      chk1("sticky_valid", dec_valid, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("target_dec", 32'h68);
    chk("target_next", imem_addr, 32'h6C);
    chk1("target_lrwe", lr_we, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("dec_6c", 32'h6C);

    // Unlinked branch while the 0x70 fetch is outstanding: drain then redirect
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h100);
    chk1("drain_req", imem_req, 1'b1);
    chk("drain_addr", imem_addr, 32'h70);
    chk1("drain_lrwe", lr_we, 1'b0);
    chk1("drain_valid", dec_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr2", imem_addr, 32'h70);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("drain_discard", dec_valid, 1'b0);
    chk("drain_target", imem_addr, 32'h170);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("drain_target_dec", 32'h170);

    // Asynchronous reset during an outstanding request, then a stale ack
    imem_ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("rst_stale_valid", dec_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b1);
    chk("rst_vec_addr", imem_addr, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_dec("rst_first_dec", 32'h0);

    // Randomized ack/stall against an in-order fetch/decode scoreboard
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    exp_fetch  = 32'h0;
    prev_stall = 1'b0;
    prev_pend  = 1'b0;
    prev_addr  = '0;
    prev_pc    = dec_pc;
    prev_iin   = dec_iin;
    prev_valid = dec_valid;
    for (int n = 0; n < 603; n++) begin
      chk("rnd_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (prev_pend) begin
        chk1("rnd_req_stable", imem_req, 1'b1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd_fetch_addr", imem_addr, exp_fetch);
      if (prev_stall) begin
        chk("rnd_hold_pc", dec_pc, prev_pc);
        chk("rnd_hold_iin", dec_iin, prev_iin);
        chk1("rnd_hold_valid", dec_valid, prev_valid);
      end else if (dec_valid) begin
        if (q.size() == 0) begin
          chk1("rnd_spurious_valid", dec_valid, 1'b0);
        end else begin
          exp_pc = q.pop_front();
          chk("rnd_dec_pc", dec_pc, exp_pc);
          chk("rnd_dec_iin", dec_iin, memf(exp_pc));
        end
      end else begin
        chk("rnd_empty_iin", dec_iin, NOP);
      end
      prev_pc    = dec_pc;
      prev_iin   = dec_iin;
      prev_valid = dec_valid;
      if (n < 600) begin
        a = imem_req && ($urandom_range(9) < 6);
        s = ($urandom_range(9) < 2);
      end else begin
        a = 1'b0;
        s = 1'b0;
      end
      if (a) begin
        q.push_back(imem_addr);
        exp_fetch = exp_fetch + 32'd4;
      end
      prev_pend  = imem_req && !a;
      prev_addr  = imem_addr;
      prev_stall = s;
      cyc(a, s, 1'b0, 1'b0, 32'h0);
    end
    chk("rnd_all_decoded", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
